// File: rtl/controller_poll_scheduler_pkg.sv
// Shared types and register-map layout for the controller poll scheduler.
package controller_poll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    KICK,
    WAIT,
    CAPTURE
  } state_t;

  // Bit positions inside the status register.
  localparam int unsigned STAT_IRQ_BIT     = 0;
  localparam int unsigned STAT_BUSY_BIT    = 1;
  localparam int unsigned STAT_OVERRUN_BIT = 2;
  localparam int unsigned STAT_POLL_LSB    = 4;

  // Register-map base offsets.
  localparam int unsigned HELD_BASE = 0;

  function automatic int unsigned pressed_base(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned released_base(input int unsigned n);
    return 2 * n;
  endfunction

  function automatic int unsigned status_addr(input int unsigned n);
    return 3 * n;
  endfunction

endpackage

// File: rtl/controller_poll_scheduler_edge_tracker.sv
// Per-pad snapshot plus sticky pressed/released flags with clear-on-read.
module controller_edge_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       capture,
  input  logic [7:0] pad,
  input  logic       clr_pressed,
  input  logic       clr_released,
  output logic [7:0] held,
  output logic [7:0] pressed,
  output logic [7:0] released,
  output logic [7:0] pressed_nxt
);

  logic [7:0] released_nxt;

  // Clear applies first, then newly-seen edges are OR-ed in so a set wins over a read-clear.
  always_comb begin
    pressed_nxt  = (clr_pressed  ? '0 : pressed)  | (capture ? (pad & ~held) : '0);
    released_nxt = (clr_released ? '0 : released) | (capture ? (~pad & held) : '0);
  end

  // Snapshot and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      held     <= '0;
      pressed  <= '0;
      released <= '0;
    end else begin
      if (capture) held <= pad;
      pressed  <= pressed_nxt;
      released <= released_nxt;
    end
  end

endmodule

// File: rtl/controller_poll_scheduler.sv
// Poll sequencer for controller_interface_m with a read-only CPU register window.
module controller_poll_scheduler
  import controller_poll_pkg::*;
#(
  parameter int unsigned NUM_CONTROLLERS = 2,
  parameter int unsigned FETCH_CYCLES    = 16,
  parameter int unsigned AUTO_PERIOD     = 0,
  localparam int unsigned AW = $clog2(3 * NUM_CONTROLLERS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vblank,
  input  logic                         poll_enable,
  output logic                         start_fetch,
  input  logic [8*NUM_CONTROLLERS-1:0] controller_data_out_LIST,
  input  logic                         cpu_read,
  input  logic [AW-1:0]                cpu_addr,
  output logic [7:0]                   cpu_data_out,
  output logic                         irq
);

  localparam int unsigned CW = (FETCH_CYCLES > 1) ? $clog2(FETCH_CYCLES) : 1;
  localparam int unsigned TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  state_t          state, state_nxt;
  logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
  logic            vblank_q;
  logic [TW-1:0]   timer;
  logic            timer_hit;
  logic            trigger;
  logic            capture;
  logic [3:0]      poll_count;
  logic            overrun;
  logic            status_rd;
  logic            any_pressed;
  logic [7:0]      status;
  logic [7:0]      rd_data;

  logic [7:0]                 held        [NUM_CONTROLLERS];
  logic [7:0]                 pressed     [NUM_CONTROLLERS];
  logic [7:0]                 released    [NUM_CONTROLLERS];
  logic [7:0]                 pressed_nxt [NUM_CONTROLLERS];
  logic [NUM_CONTROLLERS-1:0] clr_pressed;
  logic [NUM_CONTROLLERS-1:0] clr_released;

  assign timer_hit = (AUTO_PERIOD != 0) && (timer == TW'(AUTO_PERIOD - 1));
  assign trigger   = poll_enable & ((vblank & ~vblank_q) | timer_hit);

  // Free-running auto-poll timer and vblank edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      vblank_q <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (AUTO_PERIOD == 0 || timer_hit) timer <= '0;
      else                               timer <= timer + 1'b1;
    end
  end

  // Poll FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Poll FSM next-state and strobes.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    start_fetch  = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE: if (trigger) state_nxt = KICK;
      KICK: begin
        start_fetch  = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (wait_cnt == CW'(FETCH_CYCLES - 1)) state_nxt = CAPTURE;
        else                                   wait_cnt_nxt = wait_cnt + 1'b1;
      end
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One edge tracker per pad.
  for (genvar g = 0; g < NUM_CONTROLLERS; g++) begin : g_pad
    controller_edge_tracker u_trk (
      .clk          (clk),
      .rst          (rst),
      .capture      (capture),
      .pad          (controller_data_out_LIST[8*g +: 8]),
      .clr_pressed  (clr_pressed[g]),
      .clr_released (clr_released[g]),
      .held         (held[g]),
      .pressed      (pressed[g]),
      .released     (released[g]),
      .pressed_nxt  (pressed_nxt[g])
    );
  end

  // Status byte assembly and register-window decode.
  always_comb begin
    status                   = '0;
    status[STAT_IRQ_BIT]     = irq;
    status[STAT_BUSY_BIT]    = (state != IDLE);
    status[STAT_OVERRUN_BIT] = overrun;
    status[STAT_POLL_LSB +: 4] = poll_count;

    rd_data      = 8'h00;
    clr_pressed  = '0;
    clr_released = '0;
    any_pressed  = 1'b0;
    for (int unsigned i = 0; i < NUM_CONTROLLERS; i++) begin
      any_pressed = any_pressed | (|pressed_nxt[i]);
      if (cpu_addr == AW'(HELD_BASE + i)) rd_data = held[i];
      if (cpu_addr == AW'(pressed_base(NUM_CONTROLLERS) + i)) begin
        rd_data        = pressed[i];
        clr_pressed[i] = cpu_read;
      end
      if (cpu_addr == AW'(released_base(NUM_CONTROLLERS) + i)) begin
        rd_data         = released[i];
        clr_released[i] = cpu_read;
      end
    end
    status_rd = 1'b0;
    if (cpu_addr == AW'(status_addr(NUM_CONTROLLERS))) begin
      rd_data   = status;
      status_rd = cpu_read;
    end
  end

  // Overrun flag, poll counter, registered read data and IRQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun      <= 1'b0;
      poll_count   <= '0;
      cpu_data_out <= 8'h00;
      irq          <= 1'b0;
    end else begin
      if (trigger && state != IDLE) overrun <= 1'b1;
      else if (status_rd)           overrun <= 1'b0;
      if (capture) poll_count <= poll_count + 1'b1;
      if (cpu_read) cpu_data_out <= rd_data;
      irq <= any_pressed;
    end
  end

endmodule
